// File: rtl/os_result_collector.sv
// os_result_collector: reassembles row-serial systolic results into a ROWS x COLS matrix behind valid/ready.
// Optional COLLECTOR_OVERRUN_EN adds sticky err_overrun_o and saturating drop_cnt_o for beats outside COLLECT.
module os_result_collector #(
  parameter int WORD_SIZE    = 16,
  parameter int ROWS         = 3,
  parameter int COLS         = 3,
  parameter int REVERSE_ROWS = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic [COLS*WORD_SIZE-1:0]      in_data_i,
  input  logic [COLS-1:0]                in_col_valid_i,
  output logic [ROWS*COLS*WORD_SIZE-1:0] result_matrix_o,
  output logic                           result_valid_o,
  input  logic                           result_ready_i,
  output logic                           busy_o,
  output logic [$clog2(ROWS+1)-1:0]      row_cnt_o
`ifdef COLLECTOR_OVERRUN_EN
  ,
  output logic                           err_overrun_o,
  output logic [7:0]                     drop_cnt_o
`endif
);
  localparam int CW = $clog2(ROWS+1);
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_e;
  state_e                         state_q;
  logic [ROWS*COLS*WORD_SIZE-1:0] mat_q;
  logic                           valid_q, busy_q;
  logic [CW-1:0]                  cnt_q;
  logic                           beat, restart;
  int                             row;
  assign beat    = |in_col_valid_i;
  // A held result must be drained before a new start is honoured.
  assign restart = start_i && (state_q != HOLD || result_ready_i);
  always_comb row = (REVERSE_ROWS != 0) ? ROWS - 1 - int'(cnt_q) : int'(cnt_q);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mat_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (restart) begin
      state_q <= COLLECT;
      mat_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        COLLECT: if (beat) begin
          for (int c = 0; c < COLS; c++)
            if (in_col_valid_i[c])
              mat_q[(row*COLS+c)*WORD_SIZE +: WORD_SIZE] <= in_data_i[c*WORD_SIZE +: WORD_SIZE];
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(ROWS-1)) begin
            state_q <= HOLD;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        HOLD: if (result_ready_i) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end
  assign result_matrix_o = mat_q;
  assign result_valid_o  = valid_q;
  assign busy_o          = busy_q;
  assign row_cnt_o       = cnt_q;
`ifdef COLLECTOR_OVERRUN_EN
  logic       err_q;
  logic [7:0] drop_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q  <= 1'b0;
      drop_q <= '0;
    end else if (restart) begin
      err_q  <= 1'b0;
      drop_q <= '0;
    end else if (beat && state_q != COLLECT) begin
      err_q  <= 1'b1;
      drop_q <= (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
    end
  end
  assign err_overrun_o = err_q;
  assign drop_cnt_o    = drop_q;
`endif
endmodule
